// File: rtl/rtc_escritura.sv
// rtc_escritura: write-side sequencer for the RTC register bus.
// A start pulse latches either the time/date set (7 registers) or the timer
// set (3 registers). Each value goes out as one req/ack bus transaction, and
// the sequence ends with a transfer-command write. A missing ack aborts the
// sequence with a one-cycle err pulse.
module rtc_escritura #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [7:0]  CMD_ADDR    = 8'hF1,
    parameter logic [7:0]  CMD_TIME    = 8'hF0,
    parameter logic [7:0]  CMD_TIMER   = 8'hF2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sel,
    input  logic [7:0] Seg,
    input  logic [7:0] Min,
    input  logic [7:0] Hor,
    input  logic [7:0] Date,
    input  logic [7:0] Mes,
    input  logic [7:0] Year,
    input  logic [7:0] Day,
    input  logic [7:0] SegT,
    input  logic [7:0] MinT,
    input  logic [7:0] HorT,
    output logic [7:0] Direc,
    output logic [7:0] WD,
    output logic       wr_req,
    input  logic       wr_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // The last WAIT cycle that is still allowed to see an ack.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_WAIT, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t     state, state_nx;
    logic       sel_q;
    logic [7:0] seg_q, min_q, hor_q, date_q, mes_q, year_q, day_q;
    logic [7:0] segt_q, mint_q, hort_q;
    logic [2:0] idx;
    logic [7:0] tmo_cnt;
    logic [7:0] tbl_addr, tbl_data;
    logic       last_entry;

    // Register table lookup: address/data pair for the current index.
    always_comb begin
        tbl_addr = 8'd0;
        tbl_data = 8'd0;
        case ({sel_q, idx})
            4'b0_000: begin tbl_addr = 8'd0;     tbl_data = seg_q;     end
            4'b0_001: begin tbl_addr = 8'd10;    tbl_data = min_q;     end
            4'b0_010: begin tbl_addr = 8'd20;    tbl_data = hor_q;     end
            4'b0_011: begin tbl_addr = 8'd30;    tbl_data = date_q;    end
            4'b0_100: begin tbl_addr = 8'd40;    tbl_data = mes_q;     end
            4'b0_101: begin tbl_addr = 8'd22;    tbl_data = year_q;    end
            4'b0_110: begin tbl_addr = 8'd24;    tbl_data = day_q;     end
            4'b0_111: begin tbl_addr = CMD_ADDR; tbl_data = CMD_TIME;  end
            4'b1_000: begin tbl_addr = 8'd26;    tbl_data = segt_q;    end
            4'b1_001: begin tbl_addr = 8'd16;    tbl_data = mint_q;    end
            4'b1_010: begin tbl_addr = 8'd5;     tbl_data = hort_q;    end
            4'b1_011: begin tbl_addr = CMD_ADDR; tbl_data = CMD_TIMER; end
            default:  begin tbl_addr = 8'd0;     tbl_data = 8'd0;      end
        endcase
    end

    // The command write is the final table entry for either set.
    assign last_entry = sel_q ? (idx == 3'd3) : (idx == 3'd7);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and status outputs; all outputs decode from state so reset
    // clears them asynchronously.
    always_comb begin
        state_nx = state;
        wr_req   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: state_nx = S_REQ;
            S_REQ:  state_nx = S_WAIT;
            S_WAIT: begin
                wr_req = 1'b1;
                // An ack in the timeout cycle still counts.
                if (wr_ack)                    state_nx = S_GAP;
                else if (tmo_cnt >= TMO_LAST)  state_nx = S_ERR;
            end
            S_GAP:  state_nx = last_entry ? S_DONE : S_LOAD;
            S_DONE: begin done = 1'b1; state_nx = S_IDLE; end
            S_ERR:  begin err  = 1'b1; state_nx = S_IDLE; end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: input latch, table index, bus address/data, timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q   <= 1'b0;
            seg_q   <= 8'd0; min_q  <= 8'd0; hor_q  <= 8'd0; date_q <= 8'd0;
            mes_q   <= 8'd0; year_q <= 8'd0; day_q  <= 8'd0;
            segt_q  <= 8'd0; mint_q <= 8'd0; hort_q <= 8'd0;
            idx     <= 3'd0;
            tmo_cnt <= 8'd0;
            Direc   <= 8'd0;
            WD      <= 8'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sel_q  <= sel;
                    seg_q  <= Seg;  min_q  <= Min;  hor_q  <= Hor;
                    date_q <= Date; mes_q  <= Mes;  year_q <= Year;
                    day_q  <= Day;
                    segt_q <= SegT; mint_q <= MinT; hort_q <= HorT;
                    idx    <= 3'd0;
                end
                S_LOAD: begin
                    Direc   <= tbl_addr;
                    WD      <= tbl_data;
                    tmo_cnt <= 8'd0;
                end
                // Saturating count of unacknowledged WAIT cycles.
                S_WAIT: if (!wr_ack && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                S_GAP:  if (!last_entry) idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_escritura.sv
// Directed bench for rtc_escritura with a small bus-driver model that acks
// after a programmable number of wait cycles and logs every accepted write.
module tb_rtc_escritura;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] Seg = 8'h45, Min = 8'h30, Hor = 8'h12, Date = 8'h04;
    logic [7:0] Mes = 8'h04, Year = 8'h17, Day = 8'h02;
    logic [7:0] SegT = 8'h00, MinT = 8'h05, HorT = 8'h01;
    logic [7:0] Direc, WD;
    logic       wr_req, busy, done, err;
    logic       wr_ack = 1'b0;

    int n_chk = 0, n_err = 0;
    int cyc = 0, p0 = 0;

    // Bus driver model state.
    int  wcnt = 0, ack_delay = 0, ack_limit = 1000, acks = 0;
    int  req_cyc = 0, n_done = 0, n_errp = 0;
    bit  unstable = 0;
    logic       preq = 1'b0;
    logic [7:0] pd = 8'd0, pw = 8'd0;
    logic [15:0] wlog[$];

    logic [15:0] exp0 [8];
    logic [15:0] exp1 [4];

    rtc_escritura #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel),
        .Seg(Seg), .Min(Min), .Hor(Hor), .Date(Date), .Mes(Mes),
        .Year(Year), .Day(Day), .SegT(SegT), .MinT(MinT), .HorT(HorT),
        .Direc(Direc), .WD(WD), .wr_req(wr_req), .wr_ack(wr_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus driver: acks after ack_delay wait cycles, logs writes, watches stability.
    always @(negedge clk) begin
        wr_ack = 1'b0;
        if (wr_req) begin
            req_cyc++;
            if (preq && (Direc != pd || WD != pw)) unstable = 1;
            if (acks < ack_limit) begin
                if (wcnt == ack_delay) begin
                    wr_ack = 1'b1; wcnt = 0; acks++;
                    wlog.push_back({Direc, WD});
                end else wcnt++;
            end
        end else wcnt = 0;
        preq = wr_req; pd = Direc; pw = WD;
        if (done) n_done++;
        if (err)  n_errp++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        wlog.delete();
        req_cyc = 0; unstable = 0; n_done = 0; n_errp = 0; acks = 0;
    endtask

    task automatic go(input logic s);
        sel = s; start = 1'b1; p0 = cyc;
        step();
        start = 1'b0;
    endtask

    // Cycle in which done/err shows, counting the start cycle as cycle 1.
    task automatic wait_end(output int lat);
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done || err) begin lat = cyc - p0 + 1; break; end
            step();
        end
    endtask

    initial begin
        int lat, rq;
        exp0 = '{{8'd0, 8'h45}, {8'd10, 8'h30}, {8'd20, 8'h12}, {8'd30, 8'h04},
                 {8'd40, 8'h04}, {8'd22, 8'h17}, {8'd24, 8'h02}, {8'hF1, 8'hF0}};
        exp1 = '{{8'd26, 8'h00}, {8'd16, 8'h05}, {8'd5, 8'h01}, {8'hF1, 8'hF2}};

        // Reset state
        step(); step();
        chk("rst_direc", {24'd0, Direc}, 32'd0);
        chk("rst_wd", {24'd0, WD}, 32'd0);
        chk("rst_outs", {28'd0, wr_req, busy, done, err}, 32'd0);
        reset = 1'b1;
        step();

        // Time/date set, zero-wait driver
        clr(); ack_delay = 0;
        go(1'b0);
        chk("t0_busy", {31'd0, busy}, 32'd1);
        wait_end(lat);
        chk("t0_lat", lat, 34);
        chk("t0_done", {31'd0, done}, 32'd1);
        chk("t0_nwr", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) chk($sformatf("t0_wr%0d", i), {16'd0, wlog[i]}, {16'd0, exp0[i]});
        step();
        chk("t0_idle", {31'd0, busy}, 32'd0);

        // Timer set, ack after 3 wait cycles (ack lands on the timeout cycle)
        clr(); ack_delay = 3;
        go(1'b1);
        wait_end(lat);
        chk("t1_lat", lat, 30);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk($sformatf("t1_wr%0d", i), {16'd0, wlog[i]}, {16'd0, exp1[i]});
        chk("t1_stable", {31'd0, unstable}, 32'd0);
        chk("t1_reqcyc", req_cyc, 16);

        // Timeout, no ack ever
        step(); clr(); ack_delay = 0; ack_limit = 0;
        go(1'b0);
        wait_end(lat);
        chk("t2_lat", lat, 8);
        chk("t2_err", {31'd0, err}, 32'd1);
        chk("t2_reqcyc", req_cyc, 4);
        for (int i = 0; i < 20; i++) step();
        chk("t2_noreq", req_cyc, 4);
        chk("t2_nerr", n_errp, 1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_ndone", n_done, 0);

        // Inputs and start changing mid-sequence; start in the done cycle
        clr(); ack_limit = 1000;
        go(1'b0);
        for (int i = 0; i < 4; i++) step();
        Hor = 8'h23; start = 1'b1;
        step();
        start = 1'b0;
        wait_end(lat);
        chk("t3_lat", lat, 34);
        chk("t3_hor", wlog.size() > 2 ? {16'd0, wlog[2]} : 32'hDEAD, {16'd0, 8'd20, 8'h12});
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_startdone", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) step();
        chk("t3_ndone", n_done, 1);
        chk("t3_nwr", wlog.size(), 8);
        chk("t3_stable", {31'd0, unstable}, 32'd0);
        Hor = 8'h12;

        // Reset while waiting for the 4th ack
        clr(); ack_limit = 3;
        go(1'b0);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (acks == 3 && wr_req) begin lat = i; break; end
            step();
        end
        chk("t4_reach", {31'd0, lat >= 0}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t4_req", {31'd0, wr_req}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_direc", {24'd0, Direc}, 32'd0);
        step();
        reset = 1'b1;
        rq = req_cyc;
        for (int i = 0; i < 12; i++) step();
        chk("t4_noreq", req_cyc, rq);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_nwr", wlog.size(), 3);
        chk("t4_ndone", n_done, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
